// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART TX arbiter slice.
//   - arb_state_t : arbiter FSM state encoding (IDLE=0, ISSUE=1, WAIT_DONE=2)
//   - DBITS_DEFAULT : default data bits per UART frame
//   - rr_pick() : rotate-and-priority-encode helper over up to RR_MAX bits
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DBITS_DEFAULT = 8;

  // Widest requester vector the pick helper handles (NREQ legal range 2..16).
  localparam int RR_MAX = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
  // The scan runs from the farthest offset down to offset 0, so the last
  // hit written is the one closest to ptr.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [3:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = 4'd0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j[3:0]]) begin
          r.found = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Requester byte-stream bundle plus the UART TX start/done handshake.
//   req_valid/req_last/req_data/req_ready : NREQ byte streams (valid & ready)
//   tx_start/tx_din/tx_done_tick          : link to the UART transmitter
//   modport master : host side (requesters and transmitter model)
//   modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBITS = DBITS_DEFAULT
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_start;
  logic [DBITS-1:0]      tx_din;
  logic                  tx_done_tick;

  modport master (
    output req_valid, req_last, req_data, tx_done_tick,
    input  req_ready, tx_start, tx_din
  );

  modport slave (
    input  req_valid, req_last, req_data, tx_done_tick,
    output req_ready, tx_start, tx_din
  );

endinterface

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Purely combinational round-robin pick of NREQ request bits.
//   valid : request vector
//   ptr   : index with highest priority this round
//   found : at least one valid bit
//   idx   : first valid index at or after ptr, wrapping modulo NREQ
// ---------------------------------------------------------------------------
module rr_priority_pick
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  logic [RR_MAX-1:0] valid_ext;
  rr_pick_t          pick;
  logic              unused_pick_bits;

  for (genvar gi = 0; gi < RR_MAX; gi++) begin : g_pad
    if (gi < NREQ) begin : g_live
      assign valid_ext[gi] = valid[gi];
    end else begin : g_zero
      assign valid_ext[gi] = 1'b0;
    end
  end

  assign pick  = rr_pick(valid_ext, 4'(ptr), NREQ);
  assign found = pick.found;
  assign idx   = pick.idx[PW-1:0];

  // Upper index bits are always zero when NREQ < 16.
  assign unused_pick_bits = ^pick.idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin, per-packet arbiter sharing one UART transmitter among NREQ
//   byte-stream requesters, with a watchdog on the transmitter's done tick.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   bus         : requester streams + transmitter handshake (slave modport)
//   grant_id    : current or last owner index
//   busy        : high outside IDLE
//   timeout_err : one-cycle pulse when the watchdog abandons a transmit
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int DBITS       = DBITS_DEFAULT,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int GW          = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_arbiter_if.slave    bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                timeout_err
);

  arb_state_t       state_reg,  state_next;
  logic [GW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]    grant_reg,  grant_next;
  logic             lock_reg,   lock_next;
  logic             last_reg,   last_next;
  logic [DBITS-1:0] tx_din_reg, tx_din_next;
  logic [31:0]      wdog_reg,   wdog_next;

  logic             tx_start_c;
  logic             timeout_c;
  logic             rr_found;
  logic [GW-1:0]    rr_idx;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic             wdog_expired;
  logic [GW-1:0]    owner_succ;
  logic [DBITS-1:0] req_bytes [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_bytes[gi] = bus.req_data[gi*DBITS +: DBITS];
  end

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_reg),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // While a packet is open only its owner may continue; a silent owner
  // therefore stalls everybody until it sends its last byte.
  always_comb begin
    win_found = rr_found;
    win_idx   = rr_idx;
    if (lock_reg) begin
      win_found = bus.req_valid[grant_reg];
      win_idx   = grant_reg;
    end
  end

  // Ready is gated by reset_n so nothing is offered while reset is held.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = reset_n && (state_reg == IDLE) && win_found
                               && (win_idx == GW'(gi));
  end

  assign wdog_expired = (TIMEOUT_CYC != 0) && (wdog_reg == 32'(TIMEOUT_CYC - 1));
  assign owner_succ   = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + GW'(1);

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    lock_next   = lock_reg;
    last_next   = last_reg;
    tx_din_next = tx_din_reg;
    wdog_next   = wdog_reg;
    tx_start_c  = 1'b0;
    timeout_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          tx_din_next = req_bytes[win_idx];
          grant_next  = win_idx;
          last_next   = bus.req_last[win_idx];
          lock_next   = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        tx_start_c = 1'b1;
        wdog_next  = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_next = wdog_reg + 32'd1;
        // A done tick in the expiry cycle wins over the watchdog.
        if (bus.tx_done_tick) begin
          if (last_reg) begin
            lock_next   = 1'b0;
            rr_ptr_next = owner_succ;
          end
          state_next = IDLE;
        end else if (wdog_expired) begin
          timeout_c   = 1'b1;
          lock_next   = 1'b0;
          rr_ptr_next = owner_succ;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      lock_reg   <= 1'b0;
      last_reg   <= 1'b0;
      tx_din_reg <= '0;
      wdog_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      lock_reg   <= lock_next;
      last_reg   <= last_next;
      tx_din_reg <= tx_din_next;
      wdog_reg   <= wdog_next;
    end
  end

  assign bus.tx_start = tx_start_c;
  assign bus.tx_din   = tx_din_reg;
  assign grant_id     = grant_reg;
  assign busy         = (state_reg != IDLE);
  assign timeout_err  = timeout_c;

endmodule
